// File: rtl/pwm_bank_shadowed.sv
// N-channel PWM bank: shared prescaled timebase, per-channel compare/polarity,
// period and compares shadowed until a period boundary. Macro: PWM_CENTER_ALIGN_EN.
module pwm_bank_shadowed #(
    parameter int CHANNELS      = 16,
    parameter int BIT_LENGTH    = 8,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           EN,
    input  logic [PRESCALE_BITS-1:0]       Prescale,
    input  logic                           Mode,
    input  logic [CHANNELS-1:0]            Polarity,
    input  logic [BIT_LENGTH-1:0]          Period,
    input  logic [BIT_LENGTH*CHANNELS-1:0] Cmps,
    input  logic                           Load,
    output logic                           Pending,
    output logic                           PeriodEnd,
    output logic [CHANNELS-1:0]            PWMs
);

    typedef logic [BIT_LENGTH-1:0] cnt_t;
    typedef logic [CHANNELS-1:0][BIT_LENGTH-1:0] cmp_t;

    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    cnt_t                     count_q, count_d;
    cnt_t                     per_a_q, per_a_d;
    cnt_t                     per_s_q, per_s_d;
    cmp_t                     cmp_a_q, cmp_a_d;
    cmp_t                     cmp_s_q, cmp_s_d;
    logic                     pend_q, pend_d;
    logic                     pe_q;
    logic [CHANNELS-1:0]      pwm_q, pwm_d;
    logic                     tick;
    logic                     bnd;
    logic                     apply;

    assign tick = EN && (presc_q == Prescale);

    always_comb begin
        presc_d = presc_q + PRESCALE_BITS'(1);
        if (!EN || tick) begin
            presc_d = '0;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_q, dir_d;

    // Dir turns down on the tick that reaches PerA, so a down-count at 1 is the boundary.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        bnd     = 1'b0;
        if (!EN) begin
            count_d = '0;
            dir_d   = 1'b0;
        end else if (tick) begin
            if (!Mode) begin
                dir_d = 1'b0;
                if (count_q >= per_a_q) begin
                    bnd     = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + cnt_t'(1);
                end
            end else if (per_a_q == '0) begin
                bnd     = 1'b1;
                count_d = '0;
                dir_d   = 1'b0;
            end else if (dir_q) begin
                if (count_q <= cnt_t'(1)) begin
                    bnd     = 1'b1;
                    count_d = '0;
                    dir_d   = 1'b0;
                end else begin
                    count_d = count_q - cnt_t'(1);
                end
            end else if (count_q >= per_a_q) begin
                count_d = count_q - cnt_t'(1);
                dir_d   = 1'b1;
            end else begin
                count_d = count_q + cnt_t'(1);
                dir_d   = (count_q + cnt_t'(1)) >= per_a_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = Mode;

    always_comb begin
        count_d = count_q;
        bnd     = 1'b0;
        if (!EN) begin
            count_d = '0;
        end else if (tick) begin
            if (count_q >= per_a_q) begin
                bnd     = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + cnt_t'(1);
            end
        end
    end
`endif

    // Halted timebase counts as a boundary: staged values may land at once.
    assign apply = bnd || !EN;

    always_comb begin
        per_a_d = per_a_q;
        cmp_a_d = cmp_a_q;
        per_s_d = per_s_q;
        cmp_s_d = cmp_s_q;
        pend_d  = pend_q;
        if (Load) begin
            per_s_d = Period;
            cmp_s_d = Cmps;
        end
        if (Load && apply) begin
            per_a_d = Period;
            cmp_a_d = Cmps;
            pend_d  = 1'b0;
        end else if (Load) begin
            pend_d = 1'b1;
        end else if (pend_q && apply) begin
            per_a_d = per_s_q;
            cmp_a_d = cmp_s_q;
            pend_d  = 1'b0;
        end
    end

    always_comb begin
        pwm_d = Polarity;
        if (EN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = (count_q < cmp_a_q[i]) ^ Polarity[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            count_q <= '0;
            per_a_q <= '0;
            per_s_q <= '0;
            cmp_a_q <= '0;
            cmp_s_q <= '0;
            pend_q  <= 1'b0;
            pe_q    <= 1'b0;
            pwm_q   <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            per_a_q <= per_a_d;
            per_s_q <= per_s_d;
            cmp_a_q <= cmp_a_d;
            cmp_s_q <= cmp_s_d;
            pend_q  <= pend_d;
            pe_q    <= bnd;
            pwm_q   <= pwm_d;
        end
    end

    assign Pending   = pend_q;
    assign PeriodEnd = pe_q;
    assign PWMs      = pwm_q;

endmodule

// File: tb/tb_pwm_bank_shadowed.sv
// Randomized bench for pwm_bank_shadowed against a tick/phase-level model.
// Center-aligned directed run is built only with PWM_CENTER_ALIGN_EN.
module tb_pwm_bank_shadowed;

    localparam int CH = 4;
    localparam int BL = 8;
    localparam int PB = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [PB-1:0]    presc = '0;
    logic             mode = 1'b0;
    logic [CH-1:0]    pol = '0;
    logic [BL-1:0]    per = '0;
    logic [CH*BL-1:0] cmps = '0;
    logic             load = 1'b0;
    logic             Pending, PeriodEnd;
    logic [CH-1:0]    PWMs;

    pwm_bank_shadowed #(
        .CHANNELS(CH), .BIT_LENGTH(BL), .PRESCALE_BITS(PB)
    ) dut (
        .CLK(clk), .RST(rst), .EN(en), .Prescale(presc), .Mode(mode),
        .Polarity(pol), .Period(per), .Cmps(cmps), .Load(load),
        .Pending(Pending), .PeriodEnd(PeriodEnd), .PWMs(PWMs)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: m_c = clocks since timebase enabled, m_k = ticks into current period.
    int       m_c, m_k, m_perA, m_perS;
    int       m_cmpA[CH];
    int       m_cmpS[CH];
    bit       m_pend, m_pe;
    bit [CH-1:0] m_pwm;

    function automatic bit m_mode();
`ifdef PWM_CENTER_ALIGN_EN
        return mode;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_len();
        if (!m_mode()) return m_perA + 1;
        return (m_perA == 0) ? 1 : 2 * m_perA;
    endfunction

    function automatic int m_count();
        if (!m_mode()) return m_k;
        return (m_k <= m_perA) ? m_k : 2 * m_perA - m_k;
    endfunction

    function automatic bit m_tick();
        return en && ((m_c % (int'(presc) + 1)) == int'(presc));
    endfunction

    function automatic bit m_bnd();
        return m_tick() && (m_k == m_len() - 1);
    endfunction

    task automatic m_reset();
        m_c = 0; m_k = 0; m_perA = 0; m_perS = 0;
        m_pend = 0; m_pe = 0; m_pwm = '0;
        for (int i = 0; i < CH; i++) begin
            m_cmpA[i] = 0;
            m_cmpS[i] = 0;
        end
    endtask

    task automatic m_edge();
        bit tk, bd;
        int cnt;
        tk = m_tick();
        bd = m_bnd();
        if (en) begin
            cnt = m_count();
            for (int i = 0; i < CH; i++)
                m_pwm[i] = (cnt < m_cmpA[i]) ^ pol[i];
            m_pe = bd;
            if (tk) m_k = bd ? 0 : m_k + 1;
            m_c++;
        end else begin
            m_c = 0; m_k = 0; m_pwm = pol; m_pe = 0;
        end
        if (load) begin
            m_perS = per;
            for (int i = 0; i < CH; i++) m_cmpS[i] = cmps[BL*i +: BL];
        end
        if (load && (bd || !en)) begin
            m_perA = m_perS;
            m_cmpA = m_cmpS;
            m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end else if (m_pend && (bd || !en)) begin
            m_perA = m_perS;
            m_cmpA = m_cmpS;
            m_pend = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check("pwms", PWMs, m_pwm);
        check("pending", Pending, m_pend);
        check("period_end", PeriodEnd, m_pe);
        load = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cmps(int c0, int c1, int c2, int c3);
        cmps = {BL'(c3), BL'(c2), BL'(c1), BL'(c0)};
    endtask

    task automatic wait_bnd(int budget);
        int t;
        t = 0;
        while (!m_bnd() && t < budget) begin
            step();
            t++;
        end
        check("boundary_reached", m_bnd(), 1);
    endtask

    int hi;

    initial begin
        m_reset();
        #2;
        check("rst_pwms", PWMs, 0);
        check("rst_pending", Pending, 0);
        check("rst_period_end", PeriodEnd, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Period 9, compares 0/3/5/12, no prescale
        per = 9; set_cmps(0, 3, 5, 12); load = 1;
        step();
        check("halt_load_direct", Pending, 0);
        en = 1;
        run(12);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hi += PWMs[1];
            check("ch0_off", PWMs[0], 0);
            check("ch3_on", PWMs[3], 1);
        end
        check("ch1_duty", hi, 3);

        // Prescale 3, period 4, compare 2
        en = 0; step();
        presc = 3; per = 4; set_cmps(2, 1, 4, 0); load = 1;
        step();
        en = 1;
        run(25);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            hi += PWMs[0];
        end
        check("presc_duty", hi, 8);

        // Mid-period load stays pending until the boundary
        en = 0; step();
        presc = 0; per = 9; set_cmps(3, 0, 0, 0); load = 1;
        step();
        en = 1;
        run(14);
        set_cmps(7, 0, 0, 0); load = 1;
        step();
        check("mid_pending", Pending, 1);
        wait_bnd(20);
        step();
        check("applied_pending", Pending, 0);
        run(12);

        // Load on the boundary cycle goes straight to active
        wait_bnd(20);
        per = 5; set_cmps(2, 6, 1, 0); load = 1;
        step();
        check("bnd_load_pending", Pending, 0);
        run(14);

        // Polarity and halted behaviour
        pol = 4'b0010;
        run(12);
        en = 0;
        run(2);
        check("halt_is_pol", PWMs, pol);
        per = 3; set_cmps(1, 1, 1, 1); load = 1;
        step();
        run(2);

`ifdef PWM_CENTER_ALIGN_EN
        mode = 1; per = 4; set_cmps(2, 4, 0, 5); load = 1;
        step();
        en = 1;
        run(24);
        en = 0; step();
        mode = 0;
`endif

        // Randomized sessions
        for (int r = 0; r < 24; r++) begin
            en = 0;
            presc = PB'($urandom_range(0, 3));
            mode = 1'($urandom_range(0, 1));
            pol = CH'($urandom);
            per = BL'($urandom_range(0, 12));
            set_cmps($urandom_range(0, int'(per) + 2), $urandom_range(0, int'(per) + 2),
                     $urandom_range(0, int'(per) + 2), $urandom_range(0, int'(per) + 2));
            load = 1;
            step();
            en = 1;
            for (int c = 0; c < 70; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    per = BL'($urandom_range(0, 12));
                    set_cmps($urandom_range(0, 14), $urandom_range(0, 14),
                             $urandom_range(0, 14), $urandom_range(0, 14));
                    load = 1;
                end
                if ($urandom_range(0, 31) == 0) pol = CH'($urandom);
                if ($urandom_range(0, 63) == 0) en = ~en;
                step();
            end
        end

        // Asynchronous reset mid-count
        en = 0; step();
        mode = 0; presc = 0; pol = 4'b1010; per = 7; set_cmps(3, 5, 8, 2); load = 1;
        step();
        en = 1;
        run(13);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("arst_pwms", PWMs, 0);
        check("arst_pending", Pending, 0);
        check("arst_period_end", PeriodEnd, 0);
        en = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
